// File: rtl/regfile_mp.sv
// regfile_mp: multi-port general-purpose register file with write-to-read
// bypass and a per-register pending table for RAW hazard detection.
//
// rdy_in is a global enable, not a handshake. When it is high, every
// enabled write or issue in that cycle takes effect at the rising edge.
// When it is low, all state holds, and no write is treated as effective.
// Reads always respond combinationally and never stall.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic [NRD-1:0]          rd_en,
    input  logic [NRD*ADDR_W-1:0]   rd_addr,
    output logic [NRD*DATA_W-1:0]   rd_data,
    output logic [NRD-1:0]          rd_busy,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR*ADDR_W-1:0]   wr_addr,
    input  logic [NWR*DATA_W-1:0]   wr_data,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_addr,
    input  logic                    flush
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [NWR-1:0]    wr_eff;
    logic              iss_eff;

    // A write port counts only when enabled, globally enabled, and not aimed at a hardwired x0
    always_comb begin
        wr_eff = '0;
        for (int j = 0; j < NWR; j++) begin
            wr_eff[j] = wr_en[j] && rdy_in &&
                        !(ZERO_REG && (wr_addr[j*ADDR_W +: ADDR_W] == '0));
        end
    end

    // An issue marks a destination pending unless it is x0 (hardwired) or the pipeline is being squashed
    assign iss_eff = rdy_in && iss_en && !flush && !(ZERO_REG && (iss_addr == '0));

    // Next register contents: later (higher-index) ports overwrite earlier ones on address collision
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NWR; j++) begin
            if (wr_eff[j]) begin
                regs_d[wr_addr[j*ADDR_W +: ADDR_W]] = wr_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // Next pending table: flush or writeback clears, then issue sets (the newer producer wins)
    always_comb begin
        busy_d = busy_q;
        if (rdy_in) begin
            if (flush) begin
                busy_d = '0;
            end else begin
                for (int j = 0; j < NWR; j++) begin
                    if (wr_eff[j]) begin
                        busy_d[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
                    end
                end
            end
            if (iss_eff) begin
                busy_d[iss_addr] = 1'b1;
            end
        end
    end

    // Register array with asynchronous clear; in-flight writes are dropped on reset
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= regs_d[k];
            end
        end
    end

    // Pending table with asynchronous clear
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // Read ports: stored value, overridden by a same-cycle effective write (highest port wins).
    // A matching write also means the result is arriving now, so the register is not pending.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (rd_en[i] && !(ZERO_REG && (rd_addr[i*ADDR_W +: ADDR_W] == '0))) begin
                rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr[i*ADDR_W +: ADDR_W]];
                rd_busy[i]                  = busy_q[rd_addr[i*ADDR_W +: ADDR_W]];
                for (int j = 0; j < NWR; j++) begin
                    if (wr_eff[j] &&
                        (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W])) begin
                        rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
                        rd_busy[i]                  = 1'b0;
                    end
                end
            end
        end
    end

endmodule
